mem_load_unit: RTL and testbench

MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

---
 rtl/mem_load_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_load_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: one aligned word read per load, byte/word alignment and extension, pipeline stall.
// Optional response watchdog enabled by defining LOAD_TIMEOUT_EN (cycle limit set by TIMEOUT).
module mem_load_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_req,
    input  logic [15:0] ld_addr,
    input  logic        ld_byte,
    input  logic        ld_signed,
    input  logic [2:0]  ld_rd,
    input  logic        flush,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic        mem_rd_valid,
    input  logic [15:0] mem_rd_data,
    output logic        stall_o,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_rd,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        cap_lsb;
    logic        cap_byte;
    logic        cap_signed;
    logic [2:0]  cap_rd;
    logic        capture;
    logic        accept;
    logic        timeout_acc;
    logic        timeout_hit;
    logic [7:0]  byte_sel;
    logic [15:0] load_result;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("mem_load_unit: TIMEOUT must be at least 1");
    end

    // A flush that coincides with the response wins: the data is dropped rather than written back.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        accept      = 1'b0;
        timeout_acc = 1'b0;
        case (state)
            IDLE: begin
                if (ld_req && !flush) begin
                    capture   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rd_valid) begin
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (flush) begin
                    state_nxt = DRAIN;
                end else if (timeout_hit) begin
                    timeout_acc = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            DRAIN: begin
                if (mem_rd_valid || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign stall_o  = !rst && (((state == IDLE) && ld_req && !flush) ||
                               (state == WAIT) ||
                               ((state == DRAIN) && ld_req));
    assign wb_valid = !rst && (state == DONE) && !flush;

    always_comb begin
        byte_sel = cap_lsb ? mem_rd_data[15:8] : mem_rd_data[7:0];
        if (cap_byte) begin
            load_result = {{8{cap_signed & byte_sel[7]}}, byte_sel};
        end else begin
            load_result = mem_rd_data;
        end
    end

    // The read strobe is simply the capture delayed by one cycle, so it marks the first WAIT cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_rd_en  <= 1'b0;
            mem_addr   <= 16'h0000;
            wb_data    <= 16'h0000;
            wb_rd      <= 3'd0;
            cap_lsb    <= 1'b0;
            cap_byte   <= 1'b0;
            cap_signed <= 1'b0;
            cap_rd     <= 3'd0;
        end else begin
            state     <= state_nxt;
            mem_rd_en <= capture;
            if (capture) begin
                mem_addr   <= {ld_addr[15:1], 1'b0};
                cap_lsb    <= ld_addr[0];
                cap_byte   <= ld_byte;
                cap_signed <= ld_signed;
                cap_rd     <= ld_rd;
            end
            if (accept) begin
                wb_data <= load_result;
                wb_rd   <= cap_rd;
            end else if (timeout_acc) begin
                wb_data <= 16'h0000;
                wb_rd   <= cap_rd;
            end
        end
    end

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             waiting;

    assign waiting     = (state == WAIT) || (state == DRAIN);
    assign timeout_hit = waiting && !mem_rd_valid && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign err_o       = err_q;

    // The count restarts whenever WAIT or DRAIN is freshly entered, including WAIT -> DRAIN on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_acc;
            if ((state_nxt == WAIT || state_nxt == DRAIN) && (state_nxt != state)) begin
                wait_cnt <= '0;
            end else if (waiting && !mem_rd_valid) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_load_unit.sv
// Self-checking bench for mem_load_unit: directed load scenarios plus randomized loads
// checked against a transaction-level reference of alignment, latency and flush behaviour.
module tb_mem_load_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic        ld_byte;
    logic        ld_signed;
    logic [2:0]  ld_rd;
    logic        flush;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        mem_rd_valid;
    logic [15:0] mem_rd_data;
    logic        stall_o;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic        err_o;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] lastData = 16'h0000;
    logic [2:0]  lastRd   = 3'd0;

    always #5 clk = ~clk;

    mem_load_unit #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_req       (ld_req),
        .ld_addr      (ld_addr),
        .ld_byte      (ld_byte),
        .ld_signed    (ld_signed),
        .ld_rd        (ld_rd),
        .flush        (flush),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .stall_o      (stall_o),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .err_o        (err_o)
    );

    // Reference result: pick the addressed byte arithmetically and extend it as an integer.
    function automatic logic [15:0] refLoad(input logic [15:0] addr, input bit byt,
                                            input bit sgn, input logic [15:0] data);
        int b;
        int v;
        if (!byt) return data;
        b = (int'(data) >> ((int'(addr) % 2) * 8)) & 255;
        if (sgn && b >= 128) v = b - 256;
        else                 v = b;
        return 16'(v);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit req, input bit fl, input bit valid, input logic [15:0] data);
        ld_req       = req;
        flush        = fl;
        mem_rd_valid = valid;
        mem_rd_data  = data;
        #1;
    endtask

    task automatic checkOutput(input string tag, input bit expStall, input bit expRdEn,
                               input bit expWbv, input bit expErr);
        chk({tag, "/stall"},    16'(stall_o),   16'(expStall));
        chk({tag, "/rd_en"},    16'(mem_rd_en), 16'(expRdEn));
        chk({tag, "/wb_valid"}, 16'(wb_valid),  16'(expWbv));
        chk({tag, "/err"},      16'(err_o),     16'(expErr));
        chk({tag, "/wb_data"},  wb_data,        lastData);
        chk({tag, "/wb_rd"},    16'(wb_rd),     16'(lastRd));
    endtask

    // One complete load: IDLE request cycle, WAIT cycles up to the response (delay = extra WAIT
    // cycles before it), optional flush at WAIT cycle flushAt, then DONE if the result survives.
    task automatic runLoad(input string name, input logic [15:0] addr, input bit byt, input bit sgn,
                           input logic [2:0] rd, input logic [15:0] data, input int delay,
                           input int flushAt, input bit reqInDrain, input bit reqInDone,
                           input bit flushInDone);
        int rdEnSeen = 0;
        bit drain    = 0;
        bit killed   = 0;
        ld_addr   = addr;
        ld_byte   = byt;
        ld_signed = sgn;
        ld_rd     = rd;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'($urandom));
        checkOutput({name, "/req"}, 1'b1, 1'b0, 1'b0, 1'b0);
        rdEnSeen += int'(mem_rd_en);
        nextCycle();
        for (int k = 0; k <= delay; k++) begin
            bit fl    = (k == flushAt);
            bit valid = (k == delay);
            bit req   = drain ? reqInDrain : !fl;
            applyStimulus(req, fl, valid, valid ? data : 16'($urandom));
            checkOutput($sformatf("%s/w%0d", name, k), drain ? req : 1'b1, k == 0, 1'b0, 1'b0);
            if (k == 0) chk({name, "/mem_addr"}, mem_addr, addr & 16'hFFFE);
            rdEnSeen += int'(mem_rd_en);
            if (fl && !valid) drain = 1;
            if (fl && valid)  killed = 1;
            nextCycle();
        end
        if (!drain && !killed) begin
            lastData = refLoad(addr, byt, sgn, data);
            lastRd   = rd;
            applyStimulus(reqInDone, flushInDone, 1'($urandom), 16'($urandom));
            checkOutput({name, "/done"}, 1'b0, 1'b0, !flushInDone, 1'b0);
            rdEnSeen += int'(mem_rd_en);
            nextCycle();
        end
        chk({name, "/rd_en_count"}, 16'(rdEnSeen), 16'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        ld_addr   = 16'h0000;
        ld_byte   = 1'b0;
        ld_signed = 1'b0;
        ld_rd     = 3'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        nextCycle();
        nextCycle();
        // Reset has priority over a pending request.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h1234);
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset/mem_addr", mem_addr, 16'h0000);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        nextCycle();
        checkOutput("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        runLoad("word0124", 16'h0124, 1'b0, 1'b0, 3'd5, 16'hBEEF, 0, -1, 1'b0, 1'b0, 1'b0);
        chk("word0124/hold", wb_data, 16'hBEEF);
        runLoad("sbyte", 16'h0011, 1'b1, 1'b1, 3'd2, 16'h80FF, 3, -1, 1'b0, 1'b0, 1'b0);
        chk("sbyte/value", wb_data, 16'hFF80);
        runLoad("ubyte", 16'h0011, 1'b1, 1'b0, 3'd3, 16'h80FF, 3, -1, 1'b0, 1'b0, 1'b0);
        chk("ubyte/value", wb_data, 16'h0080);
        runLoad("lowbyte", 16'h0010, 1'b1, 1'b1, 3'd4, 16'h807F, 1, -1, 1'b0, 1'b0, 1'b0);
        chk("lowbyte/value", wb_data, 16'h007F);

        // Flush in the second WAIT cycle, response two cycles later, next load queued behind the drain.
        runLoad("flushdrain", 16'h2000, 1'b0, 1'b0, 3'd6, 16'hDEAD, 3, 1, 1'b1, 1'b0, 1'b0);
        chk("flushdrain/kept", wb_data, 16'h0080 & 16'h0000 | 16'h007F);
        runLoad("afterdrain", 16'h2002, 1'b0, 1'b0, 3'd1, 16'h5A5A, 0, -1, 1'b0, 1'b1, 1'b0);
        runLoad("backtoback", 16'h2004, 1'b1, 1'b0, 3'd7, 16'hA5C3, 1, -1, 1'b0, 1'b1, 1'b0);
        runLoad("flushvalid", 16'h3000, 1'b0, 1'b0, 3'd2, 16'h1111, 1, 1, 1'b0, 1'b0, 1'b0);
        runLoad("flushdone", 16'h3002, 1'b0, 1'b0, 3'd3, 16'h2222, 0, -1, 1'b0, 1'b0, 1'b1);

        // A flush in IDLE blocks capture even with a request present.
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("idleflush", 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF);
        checkOutput("idleflush/next", 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("idlestray", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef LOAD_TIMEOUT_EN
        ld_addr = 16'h4000;
        ld_rd   = 3'd5;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        nextCycle();
        for (int k = 0; k < TO; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'($urandom));
            checkOutput($sformatf("timeout/w%0d", k), 1'b1, k == 0, 1'b0, 1'b0);
            nextCycle();
        end
        lastData = 16'h0000;
        lastRd   = 3'd5;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("timeout/done", 1'b0, 1'b0, 1'b1, 1'b1);
        nextCycle();
        checkOutput("timeout/after", 1'b0, 1'b0, 1'b0, 1'b0);
`else
        begin
            int longWait = 20;
            ld_addr = 16'h4001;
            ld_byte = 1'b0;
            ld_rd   = 3'd5;
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
            nextCycle();
            for (int k = 0; k < longWait; k++) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 16'($urandom));
                checkOutput($sformatf("unbounded/w%0d", k), 1'b1, k == 0, 1'b0, 1'b0);
                nextCycle();
            end
            applyStimulus(1'b1, 1'b0, 1'b1, 16'h7E57);
            nextCycle();
            lastData = 16'h7E57;
            lastRd   = 3'd5;
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
            checkOutput("unbounded/done", 1'b0, 1'b0, 1'b1, 1'b0);
            nextCycle();
        end
`endif

        for (int i = 0; i < 40; i++) begin
            int          delay = $urandom_range(0, TO - 1);
            int          flAt  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, delay) : -1;
            logic [15:0] addr  = 16'($urandom);
            logic [15:0] data  = 16'($urandom);
            runLoad($sformatf("rnd%0d", i), addr, 1'($urandom), 1'($urandom), 3'($urandom),
                    data, delay, flAt, 1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, 1'b0, 1'($urandom), 16'($urandom));
                checkOutput($sformatf("rnd%0d/gap", i), 1'b0, 1'b0, 1'b0, 1'b0);
                nextCycle();
            end
        end

        // Reset in the middle of WAIT abandons the load; a stray response afterwards is ignored.
        ld_addr = 16'h5555;
        ld_byte = 1'b0;
        ld_rd   = 3'd6;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        nextCycle();
        rst      = 1'b0;
        lastData = 16'h0000;
        lastRd   = 3'd0;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hCAFE);
        checkOutput("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midreset/mem_addr", mem_addr, 16'h0000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("midreset/after", 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
